// File: rtl/neuron_buffer_pingpong_pkg.sv
// Shared types and defaults for the ping/pong neuron buffer.
package nb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } io_state_t;

  localparam int unsigned DEF_LOG_D = 2;
  localparam int unsigned DEF_A     = 7;
  localparam int unsigned DEF_W     = 16;

  // Lanes per half and words per bank for the default configuration.
  localparam int unsigned D = 1 << DEF_LOG_D;
  localparam int unsigned N = 1 << DEF_A;

  // LSB position of a lane inside a packed lane vector.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/neuron_buffer_pingpong_buffer_half.sv
// One buffer half: D banks of N x W synchronous RAM with a full-vector port
// and a single-word (bank-selected) port. Ports are never used together.
module buffer_half
  import nb_pkg::*;
#(
  parameter int unsigned LOG_D = DEF_LOG_D,
  parameter int unsigned A     = DEF_A,
  parameter int unsigned W     = DEF_W
) (
  input  logic                        clk,
  input  logic                        vec_re,
  input  logic                        vec_we,
  input  logic [A-1:0]                vec_addr,
  input  logic [W*(1<<LOG_D)-1:0]     vec_wdata,
  output logic [W*(1<<LOG_D)-1:0]     vec_rdata,
  input  logic                        word_re,
  input  logic                        word_we,
  input  logic [LOG_D-1:0]            word_bank,
  input  logic [A-1:0]                word_addr,
  input  logic [W-1:0]                word_wdata,
  output logic [W-1:0]                word_rdata
);

  localparam int unsigned LANES = 1 << LOG_D;
  localparam int unsigned WORDS = 1 << A;

  logic [W-1:0]     bank_rd [LANES];
  logic [LOG_D-1:0] sel_q, sel_d;
  logic             vec_sel;

  assign vec_sel = vec_re | vec_we;

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [W-1:0] mem [WORDS];
    logic [W-1:0] rd_q;
    logic         hit;
    logic         we;
    logic         re;
    logic [A-1:0] addr;
    logic [W-1:0] wdata;

    // Bank port steering: vector access uses every bank, word access only the selected one.
    always_comb begin
      hit   = (word_bank == LOG_D'(b));
      we    = vec_we | (word_we & hit);
      re    = vec_re | (word_re & hit);
      addr  = vec_sel ? vec_addr : word_addr;
      wdata = vec_we ? vec_wdata[lane_lsb(b, W) +: W] : word_wdata;
    end

    // Synchronous RAM; read register holds while not reading.
    always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rd_q <= mem[addr];
    end

    assign vec_rdata[lane_lsb(b, W) +: W] = rd_q;
    assign bank_rd[b] = rd_q;
  end

  // Remember which bank a word read targeted so its data can be picked next cycle.
  always_comb begin
    sel_d = word_re ? word_bank : sel_q;
  end

  // Bank-select register for the word read path.
  always_ff @(posedge clk) begin
    sel_q <= sel_d;
  end

  assign word_rdata = bank_rd[sel_q];

endmodule

// File: rtl/neuron_buffer_pingpong.sv
// Ping/pong neuron buffer: CU owns the active half (vector port), the IO FSM
// loads or drains the shadow half word by word; swap exchanges the halves.
module neuron_buffer_pingpong
  import nb_pkg::*;
#(
  parameter int unsigned LOG_D = DEF_LOG_D,
  parameter int unsigned A     = DEF_A,
  parameter int unsigned W     = DEF_W
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic [A-1:0]            cu_addr,
  input  logic                    cu_rd_en,
  input  logic                    cu_wr_en,
  input  logic [W*(1<<LOG_D)-1:0] cu_wdata,
  output logic [W*(1<<LOG_D)-1:0] cu_rdata,
  output logic                    cu_rvalid,
  input  logic                    io_start,
  input  logic                    io_dir,
  input  logic [A-1:0]            io_base,
  input  logic [A+LOG_D:0]        io_len,
  input  logic                    io_in_valid,
  output logic                    io_in_ready,
  input  logic [W-1:0]            io_in_data,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [W-1:0]            io_out_data,
  output logic                    io_busy,
  output logic                    io_done,
  input  logic                    swap,
  output logic                    swap_ack,
  output logic                    active_half
);

  localparam int unsigned LANES = 1 << LOG_D;
  localparam int unsigned LW    = A + LOG_D + 1;
  localparam int unsigned VW    = W * LANES;

  io_state_t      state_q, state_d;
  logic [LW-1:0]  k_q, k_d;       // words written (LOAD) / accepted (DRAIN)
  logic [LW-1:0]  rk_q, rk_d;     // words read from RAM (DRAIN prefetch)
  logic [LW-1:0]  len_q, len_d;
  logic [A-1:0]   base_q, base_d;
  logic           act_q, act_d;
  logic           pend_q, pend_d;
  logic           done_q, done_d;
  logic           ack_q, ack_d;
  logic           p_q, p_d;       // RAM read register holds an unconsumed word
  logic           ov_q, ov_d;
  logic [W-1:0]   od_q, od_d;
  logic           rv_q, rv_d;
  logic           rh_q, rh_d;     // half that served the outstanding CU read
  logic [VW-1:0]  hold_q, hold_d;

  logic           cu_re;
  logic           load_hs;
  logic           accept;
  logic           move;
  logic           issue;
  logic           swap_now;
  logic [LOG_D-1:0] io_bank;
  logic [A-1:0]   io_addr;
  logic [VW-1:0]  h_vec_rdata  [2];
  logic [W-1:0]   h_word_rdata [2];

  assign cu_re = cu_rd_en & ~cu_wr_en;

  // Word index -> bank/address for whichever IO direction is running.
  always_comb begin
    if (state_q == LOAD) begin
      io_bank = k_q[LOG_D-1:0];
      io_addr = base_q + A'(k_q >> LOG_D);
    end else begin
      io_bank = rk_q[LOG_D-1:0];
      io_addr = base_q + A'(rk_q >> LOG_D);
    end
  end

  for (genvar h = 0; h < 2; h++) begin : g_half
    logic is_act;
    assign is_act = (act_q == 1'(h));

    buffer_half #(
      .LOG_D (LOG_D),
      .A     (A),
      .W     (W)
    ) u_half (
      .clk        (CLK),
      .vec_re     (cu_re & is_act),
      .vec_we     (cu_wr_en & is_act),
      .vec_addr   (cu_addr),
      .vec_wdata  (cu_wdata),
      .vec_rdata  (h_vec_rdata[h]),
      .word_re    (issue & ~is_act),
      .word_we    (load_hs & ~is_act),
      .word_bank  (io_bank),
      .word_addr  (io_addr),
      .word_wdata (io_in_data),
      .word_rdata (h_word_rdata[h])
    );
  end

  // CU read return path; data is held between reads.
  always_comb begin
    rv_d   = cu_re;
    rh_d   = act_q;
    hold_d = rv_q ? h_vec_rdata[rh_q] : hold_q;
  end

  assign cu_rdata  = hold_d;
  assign cu_rvalid = rv_q;

  // IO FSM next state, drain pipeline and swap arbitration.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    rk_d     = rk_q;
    len_d    = len_q;
    base_d   = base_q;
    act_d    = act_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    ack_d    = 1'b0;
    swap_now = 1'b0;

    load_hs = (state_q == LOAD) & io_in_valid;
    accept  = ov_q & io_out_ready;
    move    = p_q & (~ov_q | accept);
    issue   = (state_q == DRAIN) & (rk_q < len_q) & (~p_q | move);

    // Two-stage drain: RAM read register feeds the one-entry output register.
    p_d  = issue ? 1'b1 : (move ? 1'b0 : p_q);
    ov_d = move ? 1'b1 : (accept ? 1'b0 : ov_q);
    od_d = move ? h_word_rdata[~act_q] : od_q;

    unique case (state_q)
      IDLE: begin
        swap_now = swap;
        if (io_start) begin
          base_d = io_base;
          len_d  = io_len;
          k_d    = '0;
          rk_d   = '0;
          if (io_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = io_dir ? DRAIN : LOAD;
          end
        end
      end
      LOAD: begin
        if (swap) pend_d = 1'b1;
        if (load_hs) begin
          k_d = k_q + LW'(1);
          if (k_q == len_q - LW'(1)) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            swap_now = swap | pend_q;
            pend_d   = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (swap) pend_d = 1'b1;
        if (issue) rk_d = rk_q + LW'(1);
        if (accept) begin
          k_d = k_q + LW'(1);
          if (k_q == len_q - LW'(1)) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            swap_now = swap | pend_q;
            pend_d   = 1'b0;
            ov_d     = 1'b0;
            p_d      = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (swap_now) begin
      act_d = ~act_q;
      ack_d = 1'b1;
    end
  end

  // State registers; RAM contents are not reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      k_q     <= '0;
      rk_q    <= '0;
      len_q   <= '0;
      base_q  <= '0;
      act_q   <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      p_q     <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      rv_q    <= 1'b0;
      rh_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rk_q    <= rk_d;
      len_q   <= len_d;
      base_q  <= base_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      p_q     <= p_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      rv_q    <= rv_d;
      rh_q    <= rh_d;
      hold_q  <= hold_d;
    end
  end

  assign io_in_ready  = (state_q == LOAD);
  assign io_out_valid = ov_q;
  assign io_out_data  = od_q;
  assign io_busy      = (state_q != IDLE);
  assign io_done      = done_q;
  assign swap_ack     = ack_q;
  assign active_half  = act_q;

endmodule

// File: tb/tb_neuron_buffer_pingpong.sv
// Scenario bench for the ping/pong neuron buffer with queue-based scoreboards.
module tb_neuron_buffer_pingpong;
  import nb_pkg::*;

  localparam int unsigned LOG_D = 2;
  localparam int unsigned A     = 7;
  localparam int unsigned W     = 16;
  localparam int unsigned LW    = A + LOG_D + 1;
  localparam int unsigned VW    = W * D;

  logic          CLK;
  logic          RSTn;
  logic [A-1:0]  cu_addr;
  logic          cu_rd_en;
  logic          cu_wr_en;
  logic [VW-1:0] cu_wdata;
  logic [VW-1:0] cu_rdata;
  logic          cu_rvalid;
  logic          io_start;
  logic          io_dir;
  logic [A-1:0]  io_base;
  logic [LW-1:0] io_len;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [W-1:0]  io_in_data;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [W-1:0]  io_out_data;
  logic          io_busy;
  logic          io_done;
  logic          swap;
  logic          swap_ack;
  logic          active_half;

  neuron_buffer_pingpong #(.LOG_D(LOG_D), .A(A), .W(W)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .cu_addr      (cu_addr),
    .cu_rd_en     (cu_rd_en),
    .cu_wr_en     (cu_wr_en),
    .cu_wdata     (cu_wdata),
    .cu_rdata     (cu_rdata),
    .cu_rvalid    (cu_rvalid),
    .io_start     (io_start),
    .io_dir       (io_dir),
    .io_base      (io_base),
    .io_len       (io_len),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_data   (io_in_data),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_data  (io_out_data),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .swap         (swap),
    .swap_ack     (swap_ack),
    .active_half  (active_half)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_active = 1'b0;

  logic [VW-1:0] exp_vec_q  [$];
  logic [W-1:0]  exp_word_q [$];

  function automatic logic [VW-1:0] vec4(input int w0, input int w1, input int w2, input int w3);
    return {W'(w3), W'(w2), W'(w1), W'(w0)};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    cu_addr = '0; cu_rd_en = 0; cu_wr_en = 0; cu_wdata = '0;
    io_start = 0; io_dir = 0; io_base = '0; io_len = '0;
    io_in_valid = 0; io_in_data = '0; io_out_ready = 0; swap = 0;
  endtask

  task automatic start_xfer(input logic dir, input logic [A-1:0] base, input logic [LW-1:0] len);
    io_start = 1; io_dir = dir; io_base = base; io_len = len;
    step();
    io_start = 0;
  endtask

  task automatic feed_words(input int first, input int count, output int timeouts);
    int g;
    timeouts = 0;
    for (int i = 0; i < count; i++) begin
      io_in_valid = 1;
      io_in_data  = W'(first + i);
      g = 0;
      while (!io_in_ready && g < 20) begin
        step();
        g++;
      end
      if (g >= 20) timeouts++;
      step();
    end
    io_in_valid = 0;
  endtask

  task automatic do_swap();
    swap = 1;
    step();
    swap = 0;
    exp_active = ~exp_active;
  endtask

  task automatic cu_issue_read(input logic [A-1:0] addr, input logic [VW-1:0] exp);
    cu_rd_en = 1;
    cu_addr  = addr;
    exp_vec_q.push_back(exp);
    step();
  endtask

  task automatic test_reset();
    int to;
    logic saw_done;
    idle_inputs();
    RSTn = 0;
    step(); step();
    RSTn = 1;
    step();
    n_cmp++;
    if ({cu_rdata, cu_rvalid, io_in_ready, io_out_valid, io_out_data, io_busy, io_done,
         swap_ack, active_half} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdata=%h rv=%b rdy=%b ov=%b od=%h busy=%b done=%b ack=%b act=%b expected all 0",
               cu_rdata, cu_rvalid, io_in_ready, io_out_valid, io_out_data, io_busy, io_done, swap_ack, active_half);
    end
    do_swap();
    n_cmp++;
    if (active_half !== 1'b1 || swap_ack !== 1'b1) begin
      n_err++;
      $display("FAIL idle_swap: got act=%b ack=%b expected 1/1", active_half, swap_ack);
    end
    start_xfer(1'b0, '0, LW'(8));
    feed_words(1, 3, to);
    #2;
    RSTn = 0;
    #1;
    n_cmp++;
    if ({cu_rdata, cu_rvalid, io_in_ready, io_out_valid, io_out_data, io_busy, io_done,
         swap_ack, active_half} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_load: got rdy=%b busy=%b done=%b act=%b expected all 0",
               io_in_ready, io_busy, io_done, active_half);
    end
    step(); step();
    RSTn = 1;
    exp_active = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (io_done) saw_done = 1;
    end
    n_cmp++;
    if (saw_done !== 1'b0 || io_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_done: got done_seen=%b busy=%b expected 0/0", saw_done, io_busy);
    end
  endtask

  task automatic test_load_swap_read();
    int to;
    logic [VW-1:0] exp;
    start_xfer(1'b0, '0, LW'(8));
    feed_words(1, 8, to);
    n_cmp++;
    if (to !== 0 || io_done !== 1'b1 || io_busy !== 1'b0) begin
      n_err++;
      $display("FAIL load_done: got timeouts=%0d done=%b busy=%b expected 0/1/0", to, io_done, io_busy);
    end
    step();
    n_cmp++;
    if (io_done !== 1'b0) begin
      n_err++;
      $display("FAIL load_done_pulse: got %b expected 0", io_done);
    end
    do_swap();
    n_cmp++;
    if (active_half !== exp_active || swap_ack !== 1'b1) begin
      n_err++;
      $display("FAIL load_swap: got act=%b ack=%b expected %b/1", active_half, swap_ack, exp_active);
    end
    for (int i = 0; i < 2; i++) begin
      cu_issue_read(A'(i), vec4(4*i+1, 4*i+2, 4*i+3, 4*i+4));
      exp = exp_vec_q.pop_front();
      n_cmp++;
      if (cu_rvalid !== 1'b1 || cu_rdata !== exp) begin
        n_err++;
        $display("FAIL load_read_%0d: got rv=%b data=%h expected 1/%h", i, cu_rvalid, cu_rdata, exp);
      end
    end
    cu_rd_en = 0;
    step();
    n_cmp++;
    if (cu_rvalid !== 1'b0 || cu_rdata !== exp) begin
      n_err++;
      $display("FAIL rdata_hold: got rv=%b data=%h expected 0/%h", cu_rvalid, cu_rdata, exp);
    end
  endtask

  task automatic test_load_wrap();
    int to;
    logic [VW-1:0] exp;
    logic [A-1:0] addrs [2];
    start_xfer(1'b0, A'(N-1), LW'(8));
    feed_words(1, 8, to);
    n_cmp++;
    if (to !== 0 || io_done !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_done: got timeouts=%0d done=%b expected 0/1", to, io_done);
    end
    step();
    do_swap();
    addrs[0] = '0;
    addrs[1] = A'(N-1);
    for (int i = 0; i < 2; i++) begin
      cu_issue_read(addrs[i], (i == 0) ? vec4(5, 6, 7, 8) : vec4(1, 2, 3, 4));
      exp = exp_vec_q.pop_front();
      n_cmp++;
      if (cu_rvalid !== 1'b1 || cu_rdata !== exp) begin
        n_err++;
        $display("FAIL wrap_read_%0d: got rv=%b data=%h expected 1/%h", i, cu_rvalid, cu_rdata, exp);
      end
    end
    cu_rd_en = 0;
    step();
  endtask

  task automatic test_drain_backpressure();
    logic stalled;
    logic [W-1:0] held;
    logic [W-1:0] exp;
    int dones;
    cu_wr_en = 1; cu_rd_en = 1; cu_addr = A'(10); cu_wdata = vec4('h100, 'h101, 'h102, 'h103);
    step();
    cu_rd_en = 0;
    n_cmp++;
    if (cu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL wr_beats_rd: got rv=%b expected 0", cu_rvalid);
    end
    cu_addr = A'(11); cu_wdata = vec4('h104, 'h105, 'h106, 'h107);
    step();
    cu_wr_en = 0;
    do_swap();
    for (int i = 0; i < 8; i++) exp_word_q.push_back(W'('h100 + i));
    start_xfer(1'b1, A'(10), LW'(8));
    io_out_ready = 0;
    stalled = 0;
    held = '0;
    dones = 0;
    for (int c = 0; c < 80 && !(exp_word_q.size() == 0 && dones > 0); c++) begin
      if (io_done) dones++;
      if (stalled) begin
        n_cmp++;
        if (io_out_valid !== 1'b1 || io_out_data !== held) begin
          n_err++;
          $display("FAIL drain_hold: got ov=%b data=%h expected 1/%h", io_out_valid, io_out_data, held);
        end
      end
      io_out_ready = ~io_out_ready;
      stalled = 0;
      if (io_out_valid) begin
        if (io_out_ready) begin
          exp = (exp_word_q.size() > 0) ? exp_word_q.pop_front() : 'x;
          n_cmp++;
          if (io_out_data !== exp) begin
            n_err++;
            $display("FAIL drain_word: got %h expected %h", io_out_data, exp);
          end
        end else begin
          stalled = 1;
          held = io_out_data;
        end
      end
      step();
    end
    io_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (io_done) dones++;
      step();
    end
    n_cmp++;
    if (exp_word_q.size() != 0 || dones != 1 || io_busy !== 1'b0 || io_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_end: got left=%0d dones=%0d busy=%b ov=%b expected 0/1/0/0",
               exp_word_q.size(), dones, io_busy, io_out_valid);
    end
    exp_word_q.delete();
  endtask

  task automatic test_swap_mid_drain();
    logic start_act;
    logic early;
    logic ack_ok;
    logic [W-1:0] exp;
    int acks;
    int dones;
    start_act = exp_active;
    for (int i = 0; i < 8; i++) exp_word_q.push_back(W'('h100 + i));
    start_xfer(1'b1, A'(10), LW'(8));
    io_out_ready = 1;
    early = 0; ack_ok = 1; acks = 0; dones = 0;
    for (int c = 0; c < 60 && !(exp_word_q.size() == 0 && dones > 0); c++) begin
      if (io_done) dones++;
      if (swap_ack) begin
        acks++;
        if (io_done !== 1'b1) ack_ok = 0;
      end
      if (active_half !== start_act && acks == 0) early = 1;
      if (io_out_valid) begin
        exp = (exp_word_q.size() > 0) ? exp_word_q.pop_front() : 'x;
        n_cmp++;
        if (io_out_data !== exp) begin
          n_err++;
          $display("FAIL swapdrain_word: got %h expected %h", io_out_data, exp);
        end
      end
      swap = (c == 2 || c == 4);
      step();
    end
    swap = 0;
    io_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (swap_ack) acks++;
      step();
    end
    exp_active = ~start_act;
    n_cmp++;
    if (early !== 1'b0 || ack_ok !== 1'b1) begin
      n_err++;
      $display("FAIL swapdrain_timing: got early=%b ack_with_done=%b expected 0/1", early, ack_ok);
    end
    n_cmp++;
    if (acks != 1 || dones != 1 || active_half !== exp_active) begin
      n_err++;
      $display("FAIL swapdrain_count: got acks=%0d dones=%0d act=%b expected 1/1/%b",
               acks, dones, active_half, exp_active);
    end
    exp_word_q.delete();
  endtask

  task automatic test_zero_len();
    logic [VW-1:0] exp;
    io_in_valid = 1;
    io_in_data  = W'('hDEAD);
    start_xfer(1'b0, '0, '0);
    n_cmp++;
    if (io_done !== 1'b1 || io_busy !== 1'b0 || io_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_done: got done=%b busy=%b rdy=%b expected 1/0/0", io_done, io_busy, io_in_ready);
    end
    step();
    io_in_valid = 0;
    n_cmp++;
    if (io_done !== 1'b0 || io_busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_after: got done=%b busy=%b expected 0/0", io_done, io_busy);
    end
    do_swap();
    n_cmp++;
    if (active_half !== exp_active) begin
      n_err++;
      $display("FAIL zero_len_swap: got %b expected %b", active_half, exp_active);
    end
    cu_issue_read('0, vec4(1, 2, 3, 4));
    exp = exp_vec_q.pop_front();
    n_cmp++;
    if (cu_rvalid !== 1'b1 || cu_rdata !== exp) begin
      n_err++;
      $display("FAIL zero_len_nowrite: got rv=%b data=%h expected 1/%h", cu_rvalid, cu_rdata, exp);
    end
    cu_rd_en = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_load_swap_read();
    test_load_wrap();
    test_drain_backpressure();
    test_swap_mid_drain();
    test_zero_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
